// File: rtl/search_pkg.sv
// search_pkg: shared state and result types for the search request master
package search_pkg;
  localparam int RULE_W = 24;
  localparam int TAB_W  = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  typedef enum logic [2:0] {IDLE, WAIT_RDY, ISSUE, WAIT_HIT, RESULT} state_t;
  typedef struct packed {
    logic              hit;
    logic              tmo;
    logic [RULE_W-1:0] key;
    logic [TAB_W-1:0]  tab;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } result_t;
endpackage

// File: rtl/search_driver_if.sv
// search_driver_if: command, search RAM and result handshakes of the search request master
interface search_driver_if #(
  parameter int NUM_TABLE = 4,
  parameter int RULE_W    = 24,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32
);
  logic                 cmd_vd_i, cmd_rdy_o;
  logic [RULE_W-1:0]    cmd_key_i;
  logic                 search_o;
  logic [RULE_W-1:0]    key_o;
  logic [NUM_TABLE-1:0] ready_i, busy_i;
  logic                 hit_vd_i, hit_i;
  logic [3:0]           hit_tab_i;
  logic [ADDR_W-1:0]    hit_addr_i;
  logic [DATA_W-1:0]    hit_data_i;
  logic                 res_vd_o, res_rdy_i, res_hit_o, res_tmo_o;
  logic [RULE_W-1:0]    res_key_o;
  logic [3:0]           res_tab_o;
  logic [ADDR_W-1:0]    res_addr_o;
  logic [DATA_W-1:0]    res_data_o;
  modport master (
    input  cmd_vd_i, cmd_key_i, ready_i, busy_i, hit_vd_i, hit_i, hit_tab_i, hit_addr_i, hit_data_i, res_rdy_i,
    output cmd_rdy_o, search_o, key_o, res_vd_o, res_hit_o, res_tmo_o, res_key_o, res_tab_o, res_addr_o, res_data_o
  );
  modport slave (
    output cmd_vd_i, cmd_key_i, ready_i, busy_i, hit_vd_i, hit_i, hit_tab_i, hit_addr_i, hit_data_i, res_rdy_i,
    input  cmd_rdy_o, search_o, key_o, res_vd_o, res_hit_o, res_tmo_o, res_key_o, res_tab_o, res_addr_o, res_data_o
  );
endinterface

// File: rtl/search_cmd_fifo.sv
// search_cmd_fifo: registered synchronous FIFO without fall-through
module search_cmd_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk_i) if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/search_driver.sv
// search_driver: one-outstanding-search request master for the search RAM with result port and statistics
module search_driver
  import search_pkg::*;
#(
  parameter int C_NUM_TABLE      = 4,
  parameter int C_RULE_WIDTH     = RULE_W,
  parameter int C_MEM_DATA_WIDTH = RULE_W + DATA_W,
  parameter int C_MEM_ADDR_WIDTH = ADDR_W,
  parameter int C_FIFO_DEPTH     = 4,
  parameter int C_TIMEOUT        = 64,
  parameter int C_CNT_WIDTH      = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  search_driver_if.master        bus,
  output logic [C_CNT_WIDTH-1:0] cnt_hit_o,
  output logic [C_CNT_WIDTH-1:0] cnt_miss_o,
  output logic [C_CNT_WIDTH-1:0] cnt_tmo_o,
  output logic                   err_spur_o,
  output logic                   idle_o
);
  localparam int TW = $clog2(C_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(C_TIMEOUT - 1);
  localparam logic [C_CNT_WIDTH-1:0] ONE = C_CNT_WIDTH'(1);
  state_t state, state_n;
  logic [TW-1:0] timer;
  logic [C_NUM_TABLE-1:0] ready, busy;
  logic [C_MEM_ADDR_WIDTH-1:0] hit_addr;
  logic [C_MEM_DATA_WIDTH-C_RULE_WIDTH-1:0] hit_data;
  logic [C_RULE_WIDTH-1:0] head, key_q;
  logic full, empty, pop, done, search_q, res_vd_q;
  result_t res;
  assign ready = bus.ready_i;
  assign busy = bus.busy_i;
  assign hit_addr = bus.hit_addr_i;
  assign hit_data = bus.hit_data_i;
  search_cmd_fifo #(.WIDTH(C_RULE_WIDTH), .DEPTH(C_FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push(bus.cmd_vd_i),
    .pop(pop),
    .wdata(bus.cmd_key_i),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     state_n = empty ? IDLE : WAIT_RDY;
      WAIT_RDY: state_n = &ready && !(|busy) ? ISSUE : WAIT_RDY;
      ISSUE:    state_n = WAIT_HIT;
      WAIT_HIT: state_n = bus.hit_vd_i || timer == TMO_LAST ? RESULT : WAIT_HIT;
      RESULT:   state_n = bus.res_rdy_i ? IDLE : RESULT;
      default:  state_n = IDLE;
    endcase
  end
  assign pop = state == IDLE && !empty;
  assign done = state == WAIT_HIT && state_n == RESULT;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      search_q <= 1'b0;
      res_vd_q <= 1'b0;
      timer <= '0;
      key_q <= '0;
      res <= '0;
      cnt_hit_o <= '0;
      cnt_miss_o <= '0;
      cnt_tmo_o <= '0;
      err_spur_o <= 1'b0;
    end else begin
      state <= state_n;
      search_q <= state_n == ISSUE;
      res_vd_q <= state_n == RESULT;
      timer <= state == ISSUE ? '0 : timer + TW'(1);
      if (pop) key_q <= head;
      if (done) res <= bus.hit_vd_i
        ? result_t'{hit: bus.hit_i, tmo: 1'b0, key: key_q, tab: bus.hit_tab_i, addr: hit_addr, data: hit_data}
        : result_t'{hit: 1'b0, tmo: 1'b1, key: key_q, tab: '0, addr: '0, data: '0};
      if (done && bus.hit_vd_i && bus.hit_i && !(&cnt_hit_o)) cnt_hit_o <= cnt_hit_o + ONE;
      if (done && bus.hit_vd_i && !bus.hit_i && !(&cnt_miss_o)) cnt_miss_o <= cnt_miss_o + ONE;
      if (done && !bus.hit_vd_i && !(&cnt_tmo_o)) cnt_tmo_o <= cnt_tmo_o + ONE;
      err_spur_o <= err_spur_o | (bus.hit_vd_i && state != WAIT_HIT);
    end
  end
  assign bus.cmd_rdy_o = !full;
  assign bus.search_o = search_q;
  assign bus.key_o = key_q;
  assign bus.res_vd_o = res_vd_q;
  assign bus.res_hit_o = res.hit;
  assign bus.res_tmo_o = res.tmo;
  assign bus.res_key_o = res.key;
  assign bus.res_tab_o = res.tab;
  assign bus.res_addr_o = res.addr;
  assign bus.res_data_o = res.data;
  assign idle_o = state == IDLE && empty;
endmodule

// File: tb/tb_search_driver.sv
// tb_search_driver: directed self-checking bench for search_driver
module tb_search_driver;
  logic clk_i, rst_i;
  logic [15:0] cnt_hit, cnt_miss, cnt_tmo;
  logic err_spur, idle;
  int checks = 0;
  int errors = 0;
  logic [23:0] keys [6];
  int nxt, got;
  logic pend, adv;

  search_driver_if #(.NUM_TABLE(4), .RULE_W(24), .ADDR_W(8), .DATA_W(32)) bus ();

  search_driver #(
    .C_NUM_TABLE(4), .C_RULE_WIDTH(24), .C_MEM_DATA_WIDTH(56), .C_MEM_ADDR_WIDTH(8),
    .C_FIFO_DEPTH(4), .C_TIMEOUT(64), .C_CNT_WIDTH(16)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(bus),
    .cnt_hit_o(cnt_hit),
    .cnt_miss_o(cnt_miss),
    .cnt_tmo_o(cnt_tmo),
    .err_spur_o(err_spur),
    .idle_o(idle)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation did not reach its summary");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [23:0] k);
    bus.cmd_vd_i = 1'b1;
    bus.cmd_key_i = k;
    step();
    bus.cmd_vd_i = 1'b0;
  endtask

  task automatic wait_search(input string tag, input logic [23:0] k);
    int n = 0;
    while (!bus.search_o && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_search"}, bus.search_o, 1);
    chk({tag, "_key"}, bus.key_o, k);
  endtask

  task automatic accept();
    bus.res_rdy_i = 1'b1;
    step();
    bus.res_rdy_i = 1'b0;
  endtask

  initial begin
    bus.cmd_vd_i = 0; bus.cmd_key_i = '0; bus.ready_i = 4'hF; bus.busy_i = 4'h0;
    bus.hit_vd_i = 0; bus.hit_i = 0; bus.hit_tab_i = '0; bus.hit_addr_i = '0; bus.hit_data_i = '0;
    bus.res_rdy_i = 0;
    keys[0] = 24'h100001; keys[1] = 24'h200002; keys[2] = 24'h300003;
    keys[3] = 24'h400004; keys[4] = 24'h500005; keys[5] = 24'h600006;
    rst_i = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    chk("rst_cmd_rdy", bus.cmd_rdy_o, 1);
    chk("rst_idle", idle, 1);
    chk("rst_outs", {bus.search_o, bus.res_vd_o, bus.res_hit_o, bus.res_tmo_o, err_spur}, 0);
    chk("rst_cnts", {cnt_hit, cnt_miss, cnt_tmo}, 0);
    chk("rst_key", bus.key_o, 0);
    step();

    // 1: hit with minimum latency
    push(24'hA5A5A5);
    chk("t1_lat1", bus.search_o, 0);
    step();
    chk("t1_lat2", bus.search_o, 0);
    step();
    chk("t1_search", bus.search_o, 1);
    chk("t1_key", bus.key_o, 24'hA5A5A5);
    chk("t1_busy_idle", idle, 0);
    step();
    chk("t1_strobe_once", bus.search_o, 0);
    repeat (6) step();
    chk("t1_no_res", bus.res_vd_o, 0);
    bus.hit_vd_i = 1; bus.hit_i = 1; bus.hit_tab_i = 4'd2; bus.hit_addr_i = 8'h3C; bus.hit_data_i = 32'h0BADF00D;
    step();
    bus.hit_vd_i = 0;
    chk("t1_res_vd", bus.res_vd_o, 1);
    chk("t1_res", {bus.res_hit_o, bus.res_tmo_o, bus.res_tab_o, bus.res_addr_o}, {1'b1, 1'b0, 4'd2, 8'h3C});
    chk("t1_res_data", bus.res_data_o, 32'h0BADF00D);
    chk("t1_res_key", bus.res_key_o, 24'hA5A5A5);
    chk("t1_cnt_hit", cnt_hit, 1);
    chk("t1_cnt_miss", cnt_miss, 0);
    accept();
    chk("t1_res_drop", bus.res_vd_o, 0);
    chk("t1_idle", idle, 1);

    // 2: miss, result held while not accepted
    push(24'h123456);
    wait_search("t2", 24'h123456);
    step();
    bus.hit_vd_i = 1; bus.hit_i = 0; bus.hit_tab_i = 4'd1; bus.hit_addr_i = 8'h55; bus.hit_data_i = 32'h11;
    step();
    bus.hit_vd_i = 0;
    for (int i = 0; i < 5; i++) begin
      bus.hit_tab_i = 4'(i + 7); bus.hit_addr_i = 8'(i * 3 + 9); bus.hit_data_i = 32'(i + 99);
      chk("t2_hold", {bus.res_vd_o, bus.res_hit_o, bus.res_tmo_o, bus.res_tab_o, bus.res_addr_o, bus.res_data_o},
          {1'b1, 1'b0, 1'b0, 4'd1, 8'h55, 32'h11});
      chk("t2_hold_key", bus.res_key_o, 24'h123456);
      step();
    end
    chk("t2_cnt_miss", cnt_miss, 1);
    chk("t2_cnt_hit", cnt_hit, 1);
    accept();

    // 3: timeout after 64 waiting cycles, then a hit in the timeout cycle wins
    bus.hit_tab_i = 4'hE; bus.hit_addr_i = 8'hEE; bus.hit_data_i = 32'hEEEE;
    push(24'h0C0FFE);
    wait_search("t3", 24'h0C0FFE);
    step();
    for (int i = 0; i < 64; i++) begin
      chk("t3_wait", bus.res_vd_o, 0);
      step();
    end
    chk("t3_res_vd", bus.res_vd_o, 1);
    chk("t3_res", {bus.res_hit_o, bus.res_tmo_o, bus.res_tab_o, bus.res_addr_o, bus.res_data_o},
        {1'b0, 1'b1, 4'd0, 8'd0, 32'd0});
    chk("t3_res_key", bus.res_key_o, 24'h0C0FFE);
    chk("t3_cnt_tmo", cnt_tmo, 1);
    accept();
    push(24'h0D0D0D);
    wait_search("t3b", 24'h0D0D0D);
    step();
    for (int i = 0; i < 63; i++) step();
    chk("t3b_wait", bus.res_vd_o, 0);
    bus.hit_vd_i = 1; bus.hit_i = 1; bus.hit_tab_i = 4'd7; bus.hit_addr_i = 8'h81; bus.hit_data_i = 32'hCAFE;
    step();
    bus.hit_vd_i = 0;
    chk("t3b_res", {bus.res_vd_o, bus.res_hit_o, bus.res_tmo_o, bus.res_tab_o, bus.res_addr_o},
        {1'b1, 1'b1, 1'b0, 4'd7, 8'h81});
    chk("t3b_cnt_tmo", cnt_tmo, 1);
    chk("t3b_cnt_hit", cnt_hit, 2);
    accept();

    // 4: launch gated by ready and busy, no timeout while waiting
    bus.ready_i = 4'b1101;
    push(24'h444444);
    for (int i = 0; i < 3; i++) begin
      chk("t4_not_ready", bus.search_o, 0);
      step();
    end
    bus.ready_i = 4'hF; bus.busy_i = 4'b0100;
    for (int i = 0; i < 30; i++) begin
      chk("t4_busy", {bus.search_o, bus.res_vd_o}, 0);
      step();
    end
    bus.busy_i = 4'h0;
    step();
    chk("t4_release", bus.search_o, 1);
    chk("t4_key", bus.key_o, 24'h444444);
    step();
    bus.hit_vd_i = 1; bus.hit_i = 1; bus.hit_tab_i = 4'd3;
    step();
    bus.hit_vd_i = 0;
    chk("t4_res", {bus.res_vd_o, bus.res_key_o}, {1'b1, 24'h444444});
    chk("t4_cnt_hit", cnt_hit, 3);
    chk("t4_cnt_tmo", cnt_tmo, 1);

    // 5: fill the FIFO while the result is held, then drain in order
    for (int i = 0; i < 4; i++) begin
      chk("t5_rdy", bus.cmd_rdy_o, 1);
      bus.cmd_vd_i = 1; bus.cmd_key_i = keys[i];
      step();
    end
    chk("t5_full", bus.cmd_rdy_o, 0);
    bus.cmd_key_i = keys[4];
    step();
    step();
    chk("t5_still_full", bus.cmd_rdy_o, 0);
    nxt = 4; got = 0; pend = 0;
    bus.res_rdy_i = 1;
    for (int c = 0; c < 300 && got < 6; c++) begin
      bus.hit_vd_i = pend; bus.hit_i = 1; pend = 0;
      if (bus.search_o) begin
        chk("t5_order", bus.key_o, keys[got]);
        got++;
        pend = 1;
      end
      bus.cmd_vd_i = nxt < 6;
      bus.cmd_key_i = keys[nxt % 6];
      adv = bus.cmd_vd_i && bus.cmd_rdy_o;
      step();
      if (adv) nxt++;
    end
    bus.hit_vd_i = pend; bus.cmd_vd_i = 0;
    step();
    bus.hit_vd_i = 0;
    step();
    step();
    bus.res_rdy_i = 0;
    chk("t5_all_searched", got, 6);
    chk("t5_all_pushed", nxt, 6);
    chk("t5_cnt_hit", cnt_hit, 9);
    chk("t5_idle", {idle, bus.cmd_rdy_o, bus.res_vd_o}, {1'b1, 1'b1, 1'b0});
    chk("t5_no_spur", err_spur, 0);

    // 6: reset abandons an in-flight search; the late answer is spurious
    push(24'h666666);
    wait_search("t6", 24'h666666);
    step();
    bus.cmd_vd_i = 1; bus.cmd_key_i = 24'h777777;
    step();
    bus.cmd_key_i = 24'h888888;
    step();
    bus.cmd_vd_i = 0;
    rst_i = 1;
    step();
    rst_i = 0;
    chk("t6_rst_idle", idle, 1);
    chk("t6_rst_cnts", {cnt_hit, cnt_miss, cnt_tmo}, 0);
    chk("t6_rst_spur", err_spur, 0);
    bus.hit_vd_i = 1; bus.hit_i = 1;
    step();
    bus.hit_vd_i = 0;
    chk("t6_spur", err_spur, 1);
    chk("t6_no_res", bus.res_vd_o, 0);
    chk("t6_cnt_hit", cnt_hit, 0);
    repeat (3) step();
    chk("t6_flushed", {idle, bus.search_o, bus.cmd_rdy_o}, {1'b1, 1'b0, 1'b1});
    chk("t6_spur_sticky", err_spur, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
